// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, format geometry helpers
// and the operand class encoding used by the conversion datapaths.
package fp_pkg;

    localparam logic [1:0] RM_RN = 2'd0;
    localparam logic [1:0] RM_RZ = 2'd1;
    localparam logic [1:0] RM_RP = 2'd2;
    localparam logic [1:0] RM_RM = 2'd3;

    typedef enum logic [2:0] {
        ZERO,
        DENORM,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    function automatic int unsigned fw(input int unsigned w);
        return (w == 64) ? 52 : 23;
    endfunction

    function automatic int unsigned ew(input int unsigned w);
        return (w == 64) ? 11 : 8;
    endfunction

    function automatic int unsigned bias(input int unsigned w);
        return (32'd1 << (ew(w) - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 field split and operand classification.
// exp_o is the unbiased exponent as an EW+1-bit two's-complement value.
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]     data_i,
    output logic             sign_o,
    output logic [ew(W):0]   exp_o,
    output logic [fw(W)-1:0] mant_o,
    output fp_class_e        cls_o
);

    localparam int unsigned FW = fw(W);
    localparam int unsigned EW = ew(W);
    localparam logic [EW:0] BIAS_V = (EW+1)'(bias(W));

    logic [EW-1:0] ef;

    assign sign_o = data_i[W-1];
    assign ef     = data_i[W-2:FW];
    assign mant_o = data_i[FW-1:0];
    assign exp_o  = {1'b0, ef} - BIAS_V;

    always_comb begin
        if (&ef) begin
            cls_o = (|mant_o) ? NAN : INF;
        end else if (ef == '0) begin
            cls_o = (|mant_o) ? DENORM : ZERO;
        end else begin
            cls_o = NORMAL;
        end
    end

endmodule

// File: rtl/fp_to_int_pipe.sv
// 3-stage float-to-integer converter (classify / align / round-negate-saturate)
// with a global-stall valid/ready handshake. `FP_TO_INT_UNSIGNED_EN adds in_unsigned.
module fp_to_int_pipe
    import fp_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_rm,
`ifdef FP_TO_INT_UNSIGNED_EN
    input  logic          in_unsigned,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_data,
    output logic          out_invalid,
    output logic          out_inexact
);

    localparam int unsigned FW   = fw(W);
    localparam int unsigned EW   = ew(W);
    localparam int unsigned SHW  = $clog2(IW);
    localparam int unsigned EXTW = IW + FW + 1;

    localparam logic [EW:0]   IW_E    = (EW+1)'(IW);
    localparam logic [IW:0]   MAX_POS = {2'b00, {(IW-1){1'b1}}};
    localparam logic [IW:0]   MAX_NEG = {2'b01, {(IW-1){1'b0}}};
    localparam logic [IW-1:0] DFLT_S  = {1'b0, {(IW-1){1'b1}}};

    logic adv;
    logic in_uns;

    logic          c_sign;
    logic [EW:0]   c_exp;
    logic [FW-1:0] c_mant;
    fp_class_e     c_cls;
    logic          c_ovf;

    logic          s1_valid_q, s1_sign_q, s1_ovf_q, s1_uns_q;
    logic [EW:0]   s1_exp_q;
    logic [FW-1:0] s1_mant_q;
    fp_class_e     s1_cls_q;
    logic [1:0]    s1_rm_q;

    logic [EXTW-1:0] ext;
    logic [IW:0]     s2_mag_d;
    logic            s2_guard_d, s2_sticky_d, s2_spec_d;

    logic          s2_valid_q, s2_sign_q, s2_uns_q;
    logic [IW:0]   s2_mag_q;
    logic          s2_guard_q, s2_sticky_q, s2_spec_q;
    logic [1:0]    s2_rm_q;

    logic          inc, in_range, invalid;
    logic [IW:0]   mag_r;
    logic [IW-1:0] mag_lo;
    logic [IW-1:0] out_data_d;
    logic          out_invalid_d, out_inexact_d;

    logic          out_valid_q, out_invalid_q, out_inexact_q;
    logic [IW-1:0] out_data_q;

`ifdef FP_TO_INT_UNSIGNED_EN
    assign in_uns = in_unsigned;
`else
    assign in_uns = 1'b0;
`endif

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    fp_classify #(.W(W)) u_classify (
        .data_i (in_data),
        .sign_o (c_sign),
        .exp_o  (c_exp),
        .mant_o (c_mant),
        .cls_o  (c_cls)
    );

    assign c_ovf = (c_cls == NORMAL) && !c_exp[EW] && (c_exp >= IW_E);

    always_comb begin
        ext         = '0;
        s2_mag_d    = '0;
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
        s2_spec_d   = (s1_cls_q == NAN) || (s1_cls_q == INF) || s1_ovf_q;
        case (s1_cls_q)
            DENORM: s2_sticky_d = 1'b1;
            NORMAL: begin
                // Shifting by e places the hidden bit at position FW+e; the
                // integer part is everything at or above bit FW.
                if (!s1_exp_q[EW]) begin
                    ext         = {{IW{1'b0}}, 1'b1, s1_mant_q} << s1_exp_q[SHW-1:0];
                    s2_mag_d    = ext[IW+FW:FW];
                    s2_guard_d  = ext[FW-1];
                    s2_sticky_d = |ext[FW-2:0];
                end else if (&s1_exp_q) begin
                    s2_guard_d  = 1'b1;
                    s2_sticky_d = |s1_mant_q;
                end else begin
                    s2_sticky_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (s2_rm_q)
            RM_RN:   inc = s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
            RM_RZ:   inc = 1'b0;
            RM_RP:   inc = !s2_sign_q && (s2_guard_q || s2_sticky_q);
            default: inc = s2_sign_q && (s2_guard_q || s2_sticky_q);
        endcase
        mag_r  = s2_mag_q + {{IW{1'b0}}, inc};
        mag_lo = mag_r[IW-1:0];
        if (s2_uns_q) begin
            in_range = s2_sign_q ? (mag_r == '0) : !mag_r[IW];
        end else begin
            in_range = s2_sign_q ? (mag_r <= MAX_NEG) : (mag_r <= MAX_POS);
        end
        invalid = s2_spec_q || !in_range;
        if (invalid) begin
            out_data_d = s2_uns_q ? '1 : DFLT_S;
        end else begin
            out_data_d = s2_sign_q ? -mag_lo : mag_lo;
        end
        out_invalid_d = invalid;
        out_inexact_d = !invalid && (s2_guard_q || s2_sticky_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_ovf_q      <= 1'b0;
            s1_uns_q      <= 1'b0;
            s1_exp_q      <= '0;
            s1_mant_q     <= '0;
            s1_cls_q      <= ZERO;
            s1_rm_q       <= '0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_uns_q      <= 1'b0;
            s2_mag_q      <= '0;
            s2_guard_q    <= 1'b0;
            s2_sticky_q   <= 1'b0;
            s2_spec_q     <= 1'b0;
            s2_rm_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q    <= in_valid;
            s1_sign_q     <= c_sign;
            s1_ovf_q      <= c_ovf;
            s1_uns_q      <= in_uns;
            s1_exp_q      <= c_exp;
            s1_mant_q     <= c_mant;
            s1_cls_q      <= c_cls;
            s1_rm_q       <= in_rm;
            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s1_sign_q;
            s2_uns_q      <= s1_uns_q;
            s2_mag_q      <= s2_mag_d;
            s2_guard_q    <= s2_guard_d;
            s2_sticky_q   <= s2_sticky_d;
            s2_spec_q     <= s2_spec_d;
            s2_rm_q       <= s1_rm_q;
            out_valid_q   <= s2_valid_q;
            out_data_q    <= out_data_d;
            out_invalid_q <= out_invalid_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_invalid = out_invalid_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench for fp_to_int_pipe: single- and double-precision instances,
// rounding modes, saturation boundaries, back-pressure and mid-flight reset.
module tb_fp_to_int_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        iv32, ir32, ov32, or32, inv32, inx32;
    logic [31:0] id32, od32;
    logic [1:0]  rm32;

    logic        iv64, ir64, ov64, or64, inv64, inx64;
    logic [63:0] id64, od64;
    logic [1:0]  rm64;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_bp[4];
    logic [31:0] ops_bp[4];

    always #5 clk = ~clk;

    fp_to_int_pipe #(.W(32), .IW(32)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (iv32),
        .in_ready    (ir32),
        .in_data     (id32),
        .in_rm       (rm32),
`ifdef FP_TO_INT_UNSIGNED_EN
        .in_unsigned (1'b0),
`endif
        .out_valid   (ov32),
        .out_ready   (or32),
        .out_data    (od32),
        .out_invalid (inv32),
        .out_inexact (inx32)
    );

    fp_to_int_pipe #(.W(64), .IW(64)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (iv64),
        .in_ready    (ir64),
        .in_data     (id64),
        .in_rm       (rm64),
`ifdef FP_TO_INT_UNSIGNED_EN
        .in_unsigned (1'b0),
`endif
        .out_valid   (ov64),
        .out_ready   (or64),
        .out_data    (od64),
        .out_invalid (inv64),
        .out_inexact (inx64)
    );

    task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One operand through an empty pipe; result must appear on the third edge.
    task automatic cvt(input bit is64, input logic [63:0] d, input logic [1:0] rm,
                       input logic [63:0] ed, input logic einv, input logic einx,
                       input string tag);
        @(negedge clk);
        if (is64) begin
            iv64 = 1'b1; id64 = d; rm64 = rm;
        end else begin
            iv32 = 1'b1; id32 = d[31:0]; rm32 = rm;
        end
        check(is64 ? ir64 : ir32, 64'd1, {tag, ".in_ready"});
        @(negedge clk);
        iv32 = 1'b0;
        iv64 = 1'b0;
        check(is64 ? ov64 : ov32, 64'd0, {tag, ".lat1"});
        @(negedge clk);
        check(is64 ? ov64 : ov32, 64'd0, {tag, ".lat2"});
        @(negedge clk);
        check(is64 ? ov64 : ov32, 64'd1, {tag, ".valid"});
        check(is64 ? od64 : {32'd0, od32}, ed, {tag, ".data"});
        check(is64 ? inv64 : inv32, {63'd0, einv}, {tag, ".invalid"});
        check(is64 ? inx64 : inx32, {63'd0, einx}, {tag, ".inexact"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        iv32 = 1'b0; id32 = '0; rm32 = RM_RN; or32 = 1'b1;
        iv64 = 1'b0; id64 = '0; rm64 = RM_RN; or64 = 1'b1;
        #1;
        check(ov32, 64'd0, "rst.ov32");
        check({32'd0, od32}, 64'd0, "rst.od32");
        check({inv32, inx32}, 64'd0, "rst.flags32");
        check(ov64, 64'd0, "rst.ov64");
        check(od64, 64'd0, "rst.od64");
        check({inv64, inx64}, 64'd0, "rst.flags64");
        @(negedge clk);
        reset = 1'b0;

        cvt(0, 64'h3FC00000, RM_RN, 64'h00000002, 0, 1, "1.5rn");
        cvt(0, 64'h3FC00000, RM_RZ, 64'h00000001, 0, 1, "1.5rz");
        cvt(0, 64'hC0200000, RM_RN, 64'hFFFFFFFE, 0, 1, "-2.5rn");
        cvt(0, 64'hC0200000, RM_RM, 64'hFFFFFFFD, 0, 1, "-2.5rm");
        cvt(0, 64'hC0200000, RM_RP, 64'hFFFFFFFE, 0, 1, "-2.5rp");
        cvt(0, 64'hC0200000, RM_RZ, 64'hFFFFFFFE, 0, 1, "-2.5rz");
        cvt(0, 64'hCF000000, RM_RN, 64'h80000000, 0, 0, "-2^31");
        cvt(0, 64'h4F000000, RM_RN, 64'h7FFFFFFF, 1, 0, "2^31");
        cvt(0, 64'h4EFFFFFF, RM_RN, 64'h7FFFFF80, 0, 0, "maxpos");
        cvt(0, 64'h7FC00000, RM_RN, 64'h7FFFFFFF, 1, 0, "nan");
        cvt(0, 64'hFF800000, RM_RZ, 64'h7FFFFFFF, 1, 0, "-inf");
        cvt(0, 64'hDF000000, RM_RN, 64'h7FFFFFFF, 1, 0, "-2^63ovf");
        cvt(0, 64'h00000000, RM_RN, 64'h00000000, 0, 0, "zero");
        cvt(0, 64'h80000000, RM_RM, 64'h00000000, 0, 0, "negzero");
        cvt(0, 64'h00000001, RM_RP, 64'h00000001, 0, 1, "dnrm_rp");
        cvt(0, 64'h80000001, RM_RM, 64'hFFFFFFFF, 0, 1, "dnrm_rm");
        cvt(0, 64'h00000001, RM_RN, 64'h00000000, 0, 1, "dnrm_rn");
        cvt(0, 64'h3F000000, RM_RN, 64'h00000000, 0, 1, "0.5rn");
        cvt(0, 64'h3F400000, RM_RN, 64'h00000001, 0, 1, "0.75rn");
        cvt(0, 64'h3E800000, RM_RP, 64'h00000001, 0, 1, "0.25rp");

        cvt(1, 64'h4330000000000001, RM_RN, 64'h0010000000000001, 0, 0, "d2^52+1");
        cvt(1, 64'h0000000000000001, RM_RP, 64'h0000000000000001, 0, 1, "d_dnrm_rp");
        cvt(1, 64'hBFF8000000000000, RM_RN, 64'hFFFFFFFFFFFFFFFE, 0, 1, "d-1.5rn");
        cvt(1, 64'hC3E0000000000000, RM_RN, 64'h8000000000000000, 0, 0, "d-2^63");
        cvt(1, 64'h43E0000000000000, RM_RN, 64'h7FFFFFFFFFFFFFFF, 1, 0, "d2^63");

        // Back-pressure: four operands, consumer stalled for five cycles.
        ops_bp = '{32'h3FC00000, 32'hC0200000, 32'h40400000, 32'hC0800000};
        exp_bp = '{32'h00000002, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFC};
        @(negedge clk);
        or32 = 1'b0;
        rm32 = RM_RN;
        for (int i = 0; i < 4; i++) begin
            iv32 = 1'b1;
            id32 = ops_bp[i];
            if (i < 3) @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check(ov32, 64'd1, "bp.stall_valid");
            check(ir32, 64'd0, "bp.stall_in_ready");
            check({32'd0, od32}, {32'd0, exp_bp[0]}, "bp.stall_data");
            @(negedge clk);
        end
        or32 = 1'b1;
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            if (ov32) got_q.push_back(od32);
            @(negedge clk);
            iv32 = 1'b0;
        end
        check(got_q.size(), 64'd4, "bp.count");
        for (int i = 0; i < 4; i++) begin
            check((i < got_q.size()) ? {32'd0, got_q[i]} : 64'hDEAD, {32'd0, exp_bp[i]}, "bp.order");
        end

        // Reset with operands in flight.
        @(negedge clk);
        iv32 = 1'b1; id32 = 32'h3FC00000;
        @(negedge clk);
        id32 = 32'hC0200000;
        @(negedge clk);
        id32 = 32'h40400000;
        @(negedge clk);
        iv32 = 1'b0;
        check(ov32, 64'd1, "rst2.pre_valid");
        reset = 1'b1;
        #1;
        check(ov32, 64'd0, "rst2.valid");
        check({32'd0, od32}, 64'd0, "rst2.data");
        check({inv32, inx32}, 64'd0, "rst2.flags");
        @(negedge clk);
        reset = 1'b0;
        cvt(0, 64'h3FC00000, RM_RZ, 64'h00000001, 0, 1, "rst2.post");
        @(negedge clk);
        check(ov32, 64'd0, "rst2.drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
